// File: rtl/seq1101_pkg.sv
// Shared definitions for the 1101-framed serial link (transmitter and detector).
package seq1101_pkg;

  // Transmitter frame phases.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SYNC = 2'd1,
    ST_DATA = 2'd2,
    ST_GAP  = 2'd3
  } state_t;

  // Sync word marking the start of every payload, sent MSB-first.
  localparam logic [3:0] SYNC_PATTERN = 4'b1101;
  localparam int         SYNC_LEN     = 4;

  // Largest of three lengths; sizes the shared phase counter.
  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return m;
  endfunction

endpackage

// File: rtl/seq1101_tx.sv
// Serial framing transmitter: per accepted word emits 1101, the word MSB-first,
// then GAP idle zeros. x, busy and done are registered; in_ready is decoded
// from state so a new word can be taken in the final gap cycle with no dead cycle.
module seq1101_tx
  import seq1101_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int GAP    = 2
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              x,
  output logic              busy,
  output logic              done
);

  localparam int CNT_W = $clog2(max3(SYNC_LEN, DATA_W, GAP));

  localparam logic [CNT_W-1:0] SYNC_LAST = CNT_W'(SYNC_LEN - 1);
  localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_W - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP - 1);

  state_t              state, nxt_state;
  logic [CNT_W-1:0]    cnt, nxt_cnt;
  logic [DATA_W-1:0]   shreg, nxt_shreg;
  logic                nxt_x, nxt_busy, nxt_done;
  logic                accept;
  logic [1:0]          sync_idx;

  // Ready in IDLE or in the last gap cycle; never while reset is asserted.
  always_comb begin
    in_ready = 1'b0;
    if (!RESET) begin
      in_ready = (state == ST_IDLE) || ((state == ST_GAP) && (cnt == GAP_LAST));
    end
  end

  assign accept = in_valid && in_ready;

  // Next-state, counter and shift register; outputs are precomputed from the
  // next state so the registered line carries the right bit in that cycle.
  always_comb begin
    nxt_state = state;
    nxt_cnt   = cnt;
    nxt_shreg = shreg;
    nxt_x     = 1'b0;
    nxt_busy  = 1'b0;
    nxt_done  = 1'b0;
    sync_idx  = 2'd0;

    case (state)
      ST_IDLE: begin
        if (accept) begin
          nxt_state = ST_SYNC;
          nxt_cnt   = '0;
          nxt_shreg = in_data;
        end
      end
      ST_SYNC: begin
        if (cnt == SYNC_LAST) begin
          nxt_state = ST_DATA;
          nxt_cnt   = '0;
        end else begin
          nxt_cnt = cnt + 1'b1;
        end
      end
      ST_DATA: begin
        nxt_shreg = shreg << 1;
        if (cnt == DATA_LAST) begin
          nxt_state = ST_GAP;
          nxt_cnt   = '0;
        end else begin
          nxt_cnt = cnt + 1'b1;
        end
      end
      ST_GAP: begin
        if (cnt == GAP_LAST) begin
          nxt_cnt = '0;
          if (accept) begin
            nxt_state = ST_SYNC;
            nxt_shreg = in_data;
          end else begin
            nxt_state = ST_IDLE;
          end
        end else begin
          nxt_cnt = cnt + 1'b1;
        end
      end
      default: begin
        nxt_state = ST_IDLE;
        nxt_cnt   = '0;
      end
    endcase

    sync_idx = 2'(SYNC_LEN - 1) - nxt_cnt[1:0];
    case (nxt_state)
      ST_SYNC: nxt_x = SYNC_PATTERN[sync_idx];
      ST_DATA: nxt_x = nxt_shreg[DATA_W-1];
      default: nxt_x = 1'b0;
    endcase
    nxt_busy = (nxt_state != ST_IDLE);
    nxt_done = (nxt_state == ST_DATA) && (nxt_cnt == DATA_LAST);
  end

  // State, counter, shift register and output registers; reset abandons any frame.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state <= ST_IDLE;
      cnt   <= '0;
      shreg <= '0;
      x     <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= nxt_state;
      cnt   <= nxt_cnt;
      shreg <= nxt_shreg;
      x     <= nxt_x;
      busy  <= nxt_busy;
      done  <= nxt_done;
    end
  end

endmodule
